// File: rtl/flag_pkg.sv
// rtl/flag_pkg.sv - shared types and defaults for the serial NZCV flag generator
package flag_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_SLICE = 4;

  typedef enum logic {
    CMP_SUB = 1'b0,
    CMP_ADD = 1'b1
  } cmp_op_e;

  typedef struct packed {
    logic N;
    logic Z;
    logic C;
    logic V;
  } nzcv_t;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

endpackage

// File: rtl/serial_flag_gen_if.sv
// rtl/serial_flag_gen_if.sv - request/flag bundle between operand source and flag generator
interface serial_flag_gen_if #(
  parameter int WIDTH = flag_pkg::DEFAULT_WIDTH
);

  logic             start;
  logic             op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             clear;
  logic             busy;
  logic             done;
  logic             N;
  logic             Z;
  logic             C;
  logic             V;

  modport master (
    output start, op, A, B, clear,
    input  busy, done, N, Z, C, V
  );

  modport slave (
    input  start, op, A, B, clear,
    output busy, done, N, Z, C, V
  );

endinterface

// File: rtl/slice_adder.sv
// rtl/slice_adder.sv - one SLICE-bit ripple step with carry into the top bit exposed
module slice_adder #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [SLICE:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
  assign sum   = total[SLICE-1:0];
  assign cout  = total[SLICE];
  // The sum bit is a^b^carry-in at every position, so the carry into the
  // top bit falls out of the sum without a second adder chain.
  assign c_msb = sum[SLICE-1] ^ a[SLICE-1] ^ b[SLICE-1];

endmodule

// File: rtl/serial_flag_gen.sv
// rtl/serial_flag_gen.sv - multi-cycle CMP/CMN unit producing registered NZCV flags
module serial_flag_gen
  import flag_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SLICE = DEFAULT_SLICE
) (
  input  logic              clk,
  input  logic              reset_n,
  serial_flag_gen_if.slave  bus
);

  localparam int NSLICES = WIDTH / SLICE;
  localparam int CNT_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICES - 1);

  generate
    if (SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : gBadParams
      $fatal(1, "serial_flag_gen: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  state_e           state;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic             carry;
  logic             zAcc;
  logic [CNT_W-1:0] cnt;
  logic             busyReg;
  logic             doneReg;
  nzcv_t            flags;

  logic [SLICE-1:0] sliceSum;
  logic             sliceCout;
  logic             sliceCmsb;
  cmp_op_e          reqOp;
  logic             sliceZero;

  assign reqOp     = cmp_op_e'(bus.op);
  assign sliceZero = (sliceSum == '0);

  slice_adder #(
    .SLICE (SLICE)
  ) uAdder (
    .a     (aReg[SLICE-1:0]),
    .b     (bReg[SLICE-1:0]),
    .cin   (carry),
    .sum   (sliceSum),
    .cout  (sliceCout),
    .c_msb (sliceCmsb)
  );

  // Control FSM and datapath: latch operands on start, add one slice per cycle, commit flags on the last slice.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      aReg    <= '0;
      bReg    <= '0;
      carry   <= 1'b0;
      zAcc    <= 1'b0;
      cnt     <= '0;
      busyReg <= 1'b0;
      doneReg <= 1'b0;
      flags   <= '0;
    end else begin
      doneReg <= 1'b0;
      case (state)
        S_IDLE: begin
          // clear outranks start so an abort can never be mistaken for a request
          if (bus.start && !bus.clear) begin
            state   <= S_RUN;
            aReg    <= bus.A;
            // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
            bReg    <= (reqOp == CMP_ADD) ? bus.B : ~bus.B;
            carry   <= (reqOp == CMP_SUB);
            zAcc    <= 1'b1;
            cnt     <= '0;
            busyReg <= 1'b1;
          end
        end
        S_RUN: begin
          if (bus.clear) begin
            state   <= S_IDLE;
            busyReg <= 1'b0;
          end else begin
            aReg  <= aReg >> SLICE;
            bReg  <= bReg >> SLICE;
            carry <= sliceCout;
            zAcc  <= zAcc & sliceZero;
            cnt   <= cnt + 1'b1;
            if (cnt == LAST_CNT) begin
              flags.N <= sliceSum[SLICE-1];
              flags.Z <= zAcc & sliceZero;
              flags.C <= sliceCout;
              flags.V <= sliceCmsb ^ sliceCout;
              doneReg <= 1'b1;
              busyReg <= 1'b0;
              state   <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = busyReg;
  assign bus.done = doneReg;
  assign bus.N    = flags.N;
  assign bus.Z    = flags.Z;
  assign bus.C    = flags.C;
  assign bus.V    = flags.V;

endmodule

// File: tb/tb_serial_flag_gen.sv
// tb/tb_serial_flag_gen.sv - scoreboard bench for serial_flag_gen
module tb_serial_flag_gen;

  localparam int WIDTH = 32;
  localparam int SLICE = 4;
  localparam int LAT   = WIDTH / SLICE;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  serial_flag_gen_if #(.WIDTH(WIDTH)) bus ();

  serial_flag_gen #(
    .WIDTH (WIDTH),
    .SLICE (SLICE)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] flags;
    int         edgeNo;
  } exp_t;

  exp_t sb[$];
  int   checks     = 0;
  int   failures   = 0;
  int   lastAccept = -100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: flags from whole-word arithmetic, not slice by slice.
  function automatic logic [3:0] refFlags(input logic op, input logic [31:0] a, input logic [31:0] b);
    longint uRes;
    longint sRes;
    logic [31:0] r;
    logic n, z, c, v;
    if (op) begin
      uRes = longint'(a) + longint'(b);
      sRes = longint'($signed(a)) + longint'($signed(b));
      c    = (uRes > 64'sh0_FFFF_FFFF);
    end else begin
      uRes = longint'(a) - longint'(b);
      sRes = longint'($signed(a)) - longint'($signed(b));
      c    = (a >= b);
    end
    r = uRes[31:0];
    n = r[31];
    z = (r == 32'd0);
    v = (sRes > 64'sd2147483647) || (sRes < -64'sd2147483648);
    return {n, z, c, v};
  endfunction

  function automatic logic [31:0] pickVal();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one start for a single edge; queue its expected result only if the bench expects acceptance.
  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] expF, input bit accepted);
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    tick();
    if (accepted) begin
      sb.push_back('{expF, cyc + LAT});
      lastAccept = cyc;
    end
    bus.start = 1'b0;
    bus.op    = 1'($urandom_range(0, 1));
    bus.A     = $urandom;
    bus.B     = $urandom;
  endtask

  // Monitor: every done pulse must match the oldest expected result, on its expected edge.
  always @(negedge clk) begin
    exp_t e;
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(bus.done), 64'd0);
      end else begin
        e = sb.pop_front();
        check("done_edge", 64'(cyc), 64'(e.edgeNo));
        check("nzcv", 64'({bus.N, bus.Z, bus.C, bus.V}), 64'(e.flags));
      end
    end else if (sb.size() > 0 && cyc > sb[0].edgeNo) begin
      e = sb.pop_front();
      check("missing_done", 64'(bus.done), 64'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0] f;
  } vec_t;

  vec_t plan[$];

  initial begin
    bit acc;
    logic op;
    logic [31:0] a, b;

    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.clear = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({bus.busy, bus.done, bus.N, bus.Z, bus.C, bus.V}), 64'd0);
    reset_n = 1'b1;
    tick();
    check("idle_busy", 64'(bus.busy), 64'd0);

    // CMP 5-3 with busy profile over the whole run
    issue(1'b0, 32'd5, 32'd3, 4'b0010, 1'b1);
    for (int i = 0; i < LAT; i++) begin
      check("busy_run", 64'(bus.busy), 64'd1);
      tick();
    end
    check("busy_after_done", 64'(bus.busy), 64'd0);
    tick();

    // Directed vectors issued back-to-back, each start in the previous done cycle
    plan.push_back('{1'b0, 32'd3,         32'd5, 4'b1000});
    plan.push_back('{1'b0, 32'd7,         32'd7, 4'b0110});
    plan.push_back('{1'b0, 32'h8000_0000, 32'd1, 4'b0011});
    plan.push_back('{1'b1, 32'h7FFF_FFFF, 32'd1, 4'b1001});
    plan.push_back('{1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0110});
    foreach (plan[i]) begin
      issue(plan[i].op, plan[i].a, plan[i].b, plan[i].f, 1'b1);
      repeat (LAT) tick();
    end

    // start during RUN is dropped; start in the done cycle is taken
    issue(1'b0, 32'd5, 32'd3, 4'b0010, 1'b1);
    repeat (2) tick();
    issue(1'b0, 32'd3, 32'd5, 4'b1000, 1'b0);
    repeat (LAT - 3) tick();
    issue(1'b0, 32'd3, 32'd5, 4'b1000, 1'b1);
    repeat (LAT + 1) tick();

    // clear mid-run keeps the previous flags and produces no done
    issue(1'b0, 32'd7, 32'd7, 4'b0110, 1'b1);
    repeat (LAT + 1) tick();
    issue(1'b0, 32'd5, 32'd3, 4'b0010, 1'b0);
    repeat (3) tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("busy_after_clear", 64'(bus.busy), 64'd0);
    repeat (LAT + 2) tick();
    check("flags_after_clear", 64'({bus.N, bus.Z, bus.C, bus.V}), 64'b0110);

    // clear and start together in IDLE: start dropped
    bus.clear = 1'b1;
    issue(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0110, 1'b0);
    bus.clear = 1'b0;
    check("busy_clear_start", 64'(bus.busy), 64'd0);
    repeat (LAT + 2) tick();
    check("busy_clear_start_later", 64'(bus.busy), 64'd0);

    // asynchronous reset mid-run
    issue(1'b0, 32'd5, 32'd3, 4'b0010, 1'b0);
    repeat (3) tick();
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", 64'({bus.busy, bus.done, bus.N, bus.Z, bus.C, bus.V}), 64'd0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    tick();
    issue(1'b0, 32'd1, 32'd1, 4'b0110, 1'b1);
    repeat (LAT + 2) tick();

    // Randomized traffic; acceptance predicted from the bench's own view of occupancy
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        op = 1'($urandom_range(0, 1));
        a  = pickVal();
        case ($urandom_range(0, 5))
          0:       b = a;
          1:       b = -a;
          default: b = pickVal();
        endcase
        acc = (cyc + 1 >= lastAccept + LAT + 1);
        issue(op, a, b, refFlags(op, a, b), acc);
      end else begin
        tick();
      end
    end

    for (int i = 0; i < 3 * LAT && sb.size() > 0; i++) tick();
    tick();
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
